// File: rtl/dcache2_expun_ctl.sv
// dcache2_expun_ctl
//   Consumes the L2 dcache tag array's eviction outputs. After reset it drives
//   the tag-RAM init sequence. In RUN it captures victim lines into a small
//   show-ahead FIFO and offers them to the writeback path on valid/ready.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   init            tag-RAM init strobe
//   initCount[7:0]  tag set index being cleared
//   init_done       high once init has completed, until reset
//   exp_valid       victim present this cycle
//   exp_odd         victim bank (0 even, 1 odd)
//   exp_addrE/O     even/odd bank victim line address {tag, set}
//   exp_dirty       victim dirty bit
//   exp_excl        victim exclusive bit
//   exp_stall       registered throttle back to the expunge requester
//   wb_valid/ready  writeback request handshake
//   wb_addr/dirty/excl/odd  head-of-FIFO victim
//   err_ovf         sticky: a victim was lost to FIFO overflow
module dcache2_expun_ctl #(
  parameter int unsigned DEPTH      = 4,
  parameter bit          FWD_CLEAN  = 1'b0,
  parameter int unsigned INIT_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        init,
  output logic [7:0]  initCount,
  output logic        init_done,
  input  logic        exp_valid,
  input  logic        exp_odd,
  input  logic [35:0] exp_addrE,
  input  logic [35:0] exp_addrO,
  input  logic        exp_dirty,
  input  logic        exp_excl,
  output logic        exp_stall,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [35:0] wb_addr,
  output logic        wb_dirty,
  output logic        wb_excl,
  output logic        wb_odd,
  output logic        err_ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  // One slot of margin: the tag pipeline can still deliver one victim after stall.
  localparam logic [CntW-1:0] StallLvl = CntW'(DEPTH - 1);
  localparam logic [7:0]      LastLine = 8'(INIT_LINES - 1);

  typedef enum logic [1:0] {StIdle0, StInit, StRun} state_e;

  state_e state_q, state_d;
  logic [7:0] init_cnt_q, init_cnt_d;
  logic       exp_stall_q, exp_stall_d;
  logic       err_ovf_q, err_ovf_d;

  logic [35:0]     addr_q  [DEPTH];
  logic [DEPTH-1:0] dirty_q, excl_q, odd_q;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        full, push, push_ok, pop;
  logic [35:0] push_addr;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle0;
      init_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StIdle0: state_d = StInit;
      StInit: begin
        if (init_cnt_q == LastLine) begin
          state_d = StRun;
        end else begin
          init_cnt_d = init_cnt_q + 8'd1;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StIdle0;
    endcase
  end

  // FSM: outputs
  always_comb begin
    init      = (state_q == StInit);
    init_done = (state_q == StRun);
    initCount = init_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Victim FIFO control
  // ---------------------------------------------------------------------------
  always_comb begin
    full      = (count_q == DepthCnt);
    wb_valid  = (count_q != '0);
    pop       = wb_valid & wb_ready;
    push      = (state_q == StRun) & exp_valid & (exp_dirty | FWD_CLEAN);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok   = push & (~full | pop);
    push_addr = exp_odd ? exp_addrO : exp_addrE;

    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CntW'(1);
    end

    err_ovf_d   = err_ovf_q | (push & full & ~pop);
    exp_stall_d = (state_d != StRun) | (count_d >= StallLvl);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_ovf_q   <= 1'b0;
      exp_stall_q <= 1'b1;
      dirty_q     <= '0;
      excl_q      <= '0;
      odd_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_ovf_q   <= err_ovf_d;
      exp_stall_q <= exp_stall_d;
      if (push_ok) begin
        addr_q[wr_ptr_q]  <= push_addr;
        dirty_q[wr_ptr_q] <= exp_dirty;
        excl_q[wr_ptr_q]  <= exp_excl;
        odd_q[wr_ptr_q]   <= exp_odd;
      end
    end
  end

  // Show-ahead: head entry drives the request straight from storage.
  always_comb begin
    wb_addr   = addr_q[rd_ptr_q];
    wb_dirty  = dirty_q[rd_ptr_q];
    wb_excl   = excl_q[rd_ptr_q];
    wb_odd    = odd_q[rd_ptr_q];
    exp_stall = exp_stall_q;
    err_ovf   = err_ovf_q;
  end

endmodule

// File: tb/tb_dcache2_expun_ctl.sv
// Randomised bench for dcache2_expun_ctl. A queue-based reference model tracks
// cycles since reset release and the victim queue; a second instance built with
// clean forwarding enabled covers the clean-victim path.
module tb_dcache2_expun_ctl;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned INIT_LINES = 256;

  logic        clk, rst;
  logic        exp_valid, exp_odd, exp_dirty, exp_excl, wb_ready;
  logic [35:0] exp_addrE, exp_addrO;

  logic        init, init_done, exp_stall, wb_valid, wb_dirty, wb_excl, wb_odd, err_ovf;
  logic [7:0]  initCount;
  logic [35:0] wb_addr;

  logic        init_c, init_done_c, exp_stall_c, wb_valid_c, wb_dirty_c, wb_excl_c;
  logic        wb_odd_c, err_ovf_c;
  logic [7:0]  initCount_c;
  logic [35:0] wb_addr_c;

  dcache2_expun_ctl #(.DEPTH(DEPTH), .FWD_CLEAN(1'b0), .INIT_LINES(INIT_LINES)) u_dut (
    .clk(clk), .rst(rst), .init(init), .initCount(initCount), .init_done(init_done),
    .exp_valid(exp_valid), .exp_odd(exp_odd), .exp_addrE(exp_addrE), .exp_addrO(exp_addrO),
    .exp_dirty(exp_dirty), .exp_excl(exp_excl), .exp_stall(exp_stall),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_dirty(wb_dirty),
    .wb_excl(wb_excl), .wb_odd(wb_odd), .err_ovf(err_ovf)
  );

  dcache2_expun_ctl #(.DEPTH(DEPTH), .FWD_CLEAN(1'b1), .INIT_LINES(INIT_LINES)) u_dut_fc (
    .clk(clk), .rst(rst), .init(init_c), .initCount(initCount_c), .init_done(init_done_c),
    .exp_valid(exp_valid), .exp_odd(exp_odd), .exp_addrE(exp_addrE), .exp_addrO(exp_addrO),
    .exp_dirty(exp_dirty), .exp_excl(exp_excl), .exp_stall(exp_stall_c),
    .wb_valid(wb_valid_c), .wb_ready(wb_ready), .wb_addr(wb_addr_c), .wb_dirty(wb_dirty_c),
    .wb_excl(wb_excl_c), .wb_odd(wb_odd_c), .err_ovf(err_ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [35:0] addr;
    logic        dirty;
    logic        excl;
    logic        odd;
  } ent_t;

  ent_t        q[$];
  bit          ovf_m;
  int unsigned e;  // rising edges since reset release
  int          n_vec, n_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: init runs on edges 1..INIT_LINES after release; RUN afterwards.
  task automatic model_edge();
    ent_t n;
    bit   pop, push;
    if (rst) begin
      if (e > INIT_LINES) begin
        pop  = (q.size() > 0) && wb_ready;
        push = exp_valid && exp_dirty;
        if (pop) void'(q.pop_front());
        if (push) begin
          if (q.size() == DEPTH) begin
            ovf_m = 1'b1;
          end else begin
            n.addr  = exp_odd ? exp_addrO : exp_addrE;
            n.dirty = exp_dirty;
            n.excl  = exp_excl;
            n.odd   = exp_odd;
            q.push_back(n);
          end
        end
      end
      e++;
    end
  endtask

  task automatic check_all();
    int unsigned ic;
    ic = (e == 0) ? 0 : ((e - 1 > 255) ? 255 : e - 1);
    check_eq("init", 64'(init), 64'(e >= 1 && e <= INIT_LINES));
    check_eq("initCount", 64'(initCount), 64'(ic));
    check_eq("init_done", 64'(init_done), 64'(e > INIT_LINES));
    check_eq("exp_stall", 64'(exp_stall), 64'(!(e > INIT_LINES) || q.size() >= DEPTH - 1));
    check_eq("wb_valid", 64'(wb_valid), 64'(q.size() != 0));
    check_eq("err_ovf", 64'(err_ovf), 64'(ovf_m));
    if (q.size() != 0) begin
      check_eq("wb_addr", 64'(wb_addr), 64'(q[0].addr));
      check_eq("wb_dirty", 64'(wb_dirty), 64'(q[0].dirty));
      check_eq("wb_excl", 64'(wb_excl), 64'(q[0].excl));
      check_eq("wb_odd", 64'(wb_odd), 64'(q[0].odd));
    end
  endtask

  // Drive inputs (called at a falling edge), clock once, then check.
  task automatic step(input logic v, input logic o, input logic [35:0] ae,
                      input logic [35:0] ao, input logic d, input logic x, input logic r);
    exp_valid = v;
    exp_odd   = o;
    exp_addrE = ae;
    exp_addrO = ao;
    exp_dirty = d;
    exp_excl  = x;
    wb_ready  = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_step(input int unsigned ready_pct);
    logic [35:0] ae, ao;
    ae = 36'({$urandom(), $urandom()});
    ao = 36'({$urandom(), $urandom()});
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ae, ao,
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 99) < ready_pct));
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 36'h0, 36'h0, 1'b0, 1'b0, r);
  endtask

  task automatic run_init();
    // Victim pulses are legal during init and must be ignored.
    for (int i = 0; i < int'(INIT_LINES) + 3; i++) begin
      step((e < INIT_LINES) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 36'hF00 + 36'(i),
           36'hE00, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    ovf_m = 1'b0;
    e     = 0;
    rst   = 1'b0;
    exp_valid = 1'b0; exp_odd = 1'b0; exp_dirty = 1'b0; exp_excl = 1'b0;
    exp_addrE = '0;   exp_addrO = '0; wb_ready = 1'b0;

    #12;
    check_all();
    check_eq("rst_wb_addr", 64'(wb_addr), 64'h0);
    check_eq("rst_fc_valid", 64'(wb_valid_c), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    check_all();

    run_init();

    // Clean victim: dropped by the default instance, forwarded by the other.
    step(1'b1, 1'b0, 36'hABC, 36'h0, 1'b0, 1'b1, 1'b0);
    check_eq("fc_valid", 64'(wb_valid_c), 64'h1);
    check_eq("fc_dirty", 64'(wb_dirty_c), 64'h0);
    check_eq("fc_addr", 64'(wb_addr_c), 64'hABC);
    check_eq("fc_excl", 64'(wb_excl_c), 64'h1);
    idle(1'b1);
    check_eq("fc_popped", 64'(wb_valid_c), 64'h0);

    // Single dirty victim from the odd bank.
    step(1'b1, 1'b1, 36'h0, 36'h123456789, 1'b1, 1'b0, 1'b1);
    check_eq("single_addr", 64'(wb_addr), 64'h123456789);
    idle(1'b1);

    // Backpressure: four fill the FIFO, the fifth overflows.
    for (int a = 1; a <= 5; a++) step(1'b1, 1'b0, 36'(a), 36'h0, 1'b1, 1'b0, 1'b0);
    check_eq("ovf_set", 64'(err_ovf), 64'h1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Full FIFO with simultaneous push and pop.
    for (int a = 1; a <= 4; a++) step(1'b1, 1'b0, 36'(a), 36'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 36'd5, 36'h0, 1'b1, 1'b0, 1'b1);
    check_eq("full_pp_head", 64'(wb_addr), 64'd2);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Random traffic with varying downstream back-pressure.
    for (int i = 0; i < 3000; i++) rand_step((i / 300) % 2 == 0 ? 30 : 85);

    // Reset mid-operation with two entries queued.
    for (int i = 0; i < int'(DEPTH) + 1; i++) idle(1'b1);
    step(1'b1, 1'b0, 36'h11, 36'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 36'h0, 36'h22, 1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_valid", 64'(wb_valid), 64'h1);
    #3;
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    e     = 0;
    #1;
    check_all();
    check_eq("rst_async_valid", 64'(wb_valid), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    run_init();
    for (int i = 0; i < 4; i++) idle(1'b0);
    for (int i = 0; i < 200; i++) rand_step(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
